// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles the ID/EX/MEM pipeline status seen by the hazard controller and
//   the forwarding/stall/flush controls it returns.
//   master : pipeline side (drives stage status, receives controls)
//   slave  : hazard_ctrl side
//   Stage status : id_rs, id_rt, id_use_rs, id_use_rt, id_md_op, id_md_read,
//                  ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite,
//                  ex_branch_taken
//   Controls     : fwd_a_sel, fwd_b_sel, stall_if_id, bubble_id_ex,
//                  flush_if_id, md_busy
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_use_rs;
   logic       id_use_rt;
   logic       id_md_op;
   logic       id_md_read;
   logic [4:0] ex_rd;
   logic       ex_regwrite;
   logic       ex_memread;
   logic [4:0] mem_rd;
   logic       mem_regwrite;
   logic       ex_branch_taken;
   logic [1:0] fwd_a_sel;
   logic [1:0] fwd_b_sel;
   logic       stall_if_id;
   logic       bubble_id_ex;
   logic       flush_if_id;
   logic       md_busy;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, id_md_op, id_md_read,
             ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite,
             ex_branch_taken,
      input  fwd_a_sel, fwd_b_sel, stall_if_id, bubble_id_ex, flush_if_id,
             md_busy
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_op, id_md_read,
             ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite,
             ex_branch_taken,
      output fwd_a_sel, fwd_b_sel, stall_if_id, bubble_id_ex, flush_if_id,
             md_busy
   );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for the 5-stage CPU. Produces registered
//   EX-stage forwarding selects (00 ID/EX, 01 EX/MEM, 10 MEM/WB), and
//   same-cycle stall / bubble / flush controls for load-use hazards, taken
//   branches and the multi-cycle mult/div unit.
//   Parameters : MD_LAT  mult/div occupancy in cycles (>=1)
//                CNT_W   down-counter width (holds MD_LAT-1)
//   Ports      : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                hz     hazard_ctrl_if.slave (stage status in, controls out)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int unsigned MD_LAT = 32,
   parameter int unsigned CNT_W  = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   hazard_ctrl_if.slave  hz
);

   typedef enum logic {IDLE, MD_BUSY} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_md_busy;
   logic [1:0]         r_fwd_a;
   logic [1:0]         r_fwd_b;

   logic               w_load_use;
   logic               w_md_hz;
   logic               w_stall;
   logic               w_flush;
   logic               w_bubble;
   logic               w_md_start;
   logic [1:0]         w_fwd_a;
   logic [1:0]         w_fwd_b;

   // ---------------- hazard detection ----------------
   assign w_load_use = hz.ex_memread && (hz.ex_rd != '0) &&
                       ((hz.id_use_rs && (hz.ex_rd == hz.id_rs)) ||
                        (hz.id_use_rt && (hz.ex_rd == hz.id_rt)));

   assign w_md_hz    = r_md_busy && (hz.id_md_op || hz.id_md_read);

   // rst_n gates the controls so nothing leaks out while reset is asserted;
   // a taken branch overrides stall since the ID instruction is wrong-path.
   assign w_flush    = rst_n && hz.ex_branch_taken;
   assign w_stall    = rst_n && !hz.ex_branch_taken && (w_load_use || w_md_hz);
   assign w_bubble   = w_stall || w_flush;

   assign w_md_start = hz.id_md_op && !w_stall && !hz.ex_branch_taken;

   // ---------------- forwarding selects ----------------
   always_comb begin
      w_fwd_a = 2'b00;
      if (hz.ex_regwrite && (hz.ex_rd != '0) && hz.id_use_rs && (hz.ex_rd == hz.id_rs))
         w_fwd_a = 2'b01;
      else if (hz.mem_regwrite && (hz.mem_rd != '0) && hz.id_use_rs && (hz.mem_rd == hz.id_rs))
         w_fwd_a = 2'b10;
   end

   always_comb begin
      w_fwd_b = 2'b00;
      if (hz.ex_regwrite && (hz.ex_rd != '0) && hz.id_use_rt && (hz.ex_rd == hz.id_rt))
         w_fwd_b = 2'b01;
      else if (hz.mem_regwrite && (hz.mem_rd != '0) && hz.id_use_rt && (hz.mem_rd == hz.id_rt))
         w_fwd_b = 2'b10;
   end

   // A bubble turns the incoming EX instruction into a NOP, so no forwarding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fwd_a <= 2'b00;
         r_fwd_b <= 2'b00;
      end else if (w_bubble) begin
         r_fwd_a <= 2'b00;
         r_fwd_b <= 2'b00;
      end else begin
         r_fwd_a <= w_fwd_a;
         r_fwd_b <= w_fwd_b;
      end
   end

   // ---------------- mult/div occupancy FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_md_busy <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_md_start) begin
                  r_state   <= MD_BUSY;
                  r_cnt     <= CNT_W'(MD_LAT - 1);
                  r_md_busy <= 1'b1;
               end
            end
            MD_BUSY: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_state   <= IDLE;
                  r_md_busy <= 1'b0;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_cnt     <= '0;
               r_md_busy <= 1'b0;
            end
         endcase
      end
   end

   assign hz.fwd_a_sel    = r_fwd_a;
   assign hz.fwd_b_sel    = r_fwd_b;
   assign hz.stall_if_id  = w_stall;
   assign hz.bubble_id_ex = w_bubble;
   assign hz.flush_if_id  = w_flush;
   assign hz.md_busy      = r_md_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. Two instances share the same stimulus:
//   u_dut4 (MD_LAT=4) and u_dut8 (MD_LAT=8). Output bundles are compared as
//   {fwd_a_sel, fwd_b_sel, stall, bubble, flush, md_busy}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if b4 ();
   hazard_ctrl_if b8 ();

   hazard_ctrl #(.MD_LAT(4), .CNT_W(6)) u_dut4 (.clk(clk), .rst_n(rst_n), .hz(b4));
   hazard_ctrl #(.MD_LAT(8), .CNT_W(6)) u_dut8 (.clk(clk), .rst_n(rst_n), .hz(b8));

   assign b8.id_rs           = b4.id_rs;
   assign b8.id_rt           = b4.id_rt;
   assign b8.id_use_rs       = b4.id_use_rs;
   assign b8.id_use_rt       = b4.id_use_rt;
   assign b8.id_md_op        = b4.id_md_op;
   assign b8.id_md_read      = b4.id_md_read;
   assign b8.ex_rd           = b4.ex_rd;
   assign b8.ex_regwrite     = b4.ex_regwrite;
   assign b8.ex_memread      = b4.ex_memread;
   assign b8.mem_rd          = b4.mem_rd;
   assign b8.mem_regwrite    = b4.mem_regwrite;
   assign b8.ex_branch_taken = b4.ex_branch_taken;

   logic [7:0] o4, o8;
   assign o4 = {b4.fwd_a_sel, b4.fwd_b_sel, b4.stall_if_id, b4.bubble_id_ex, b4.flush_if_id, b4.md_busy};
   assign o8 = {b8.fwd_a_sel, b8.fwd_b_sel, b8.stall_if_id, b8.bubble_id_ex, b8.flush_if_id, b8.md_busy};

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      b4.id_rs = '0; b4.id_rt = '0; b4.id_use_rs = 1'b0; b4.id_use_rt = 1'b0;
      b4.id_md_op = 1'b0; b4.id_md_read = 1'b0;
      b4.ex_rd = '0; b4.ex_regwrite = 1'b0; b4.ex_memread = 1'b0;
      b4.mem_rd = '0; b4.mem_regwrite = 1'b0; b4.ex_branch_taken = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      clr();
      for (int i = 0; i < 20; i++) begin
         if (!b4.md_busy && !b8.md_busy) begin
            done = 1'b1;
            break;
         end
         cyc();
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL wait_idle: busy4=%b busy8=%b required both 0 within 20 cycles", b4.md_busy, b8.md_busy);
      end
   endtask

   task automatic test_reset();
      clr();
      // hazard-looking inputs while reset is held must not produce controls
      b4.ex_memread = 1'b1; b4.ex_rd = 5'd3; b4.id_rs = 5'd3; b4.id_use_rs = 1'b1;
      b4.ex_branch_taken = 1'b1; b4.ex_regwrite = 1'b1;
      #2;
      vectors++;
      if (o4 !== 8'b00_00_0000) begin miscompares++; $display("FAIL reset4: got %b required %b", o4, 8'b0); end
      vectors++;
      if (o8 !== 8'b00_00_0000) begin miscompares++; $display("FAIL reset8: got %b required %b", o8, 8'b0); end
      cyc(); cyc();
      vectors++;
      if (o4 !== 8'b00_00_0000) begin miscompares++; $display("FAIL reset4_held: got %b required %b", o4, 8'b0); end
      clr();
      rst_n = 1'b1;
      cyc();
      vectors++;
      if (o4 !== 8'b00_00_0000) begin miscompares++; $display("FAIL reset_release: got %b required %b", o4, 8'b0); end
   endtask

   task automatic test_md_reset();
      clr();
      b4.id_md_op = 1'b1;
      cyc();                                  // cycle 1: unit busy
      b4.id_md_op = 1'b0;
      b4.ex_rd = 5'd5; b4.ex_regwrite = 1'b1; b4.id_rs = 5'd5; b4.id_use_rs = 1'b1;
      cyc();                                  // cycle 2: fwd_a registered
      vectors++;
      if (o8 !== 8'b01_00_0001) begin miscompares++; $display("FAIL mdrst_pre: got %b required %b", o8, 8'b01_00_0001); end
      cyc(); cyc();                           // cycle 4, dut8 still busy
      rst_n = 1'b0;
      #1;
      vectors++;
      if (o8 !== 8'b00_00_0000) begin miscompares++; $display("FAIL mdrst_async8: got %b required %b", o8, 8'b0); end
      vectors++;
      if (o4 !== 8'b00_00_0000) begin miscompares++; $display("FAIL mdrst_async4: got %b required %b", o4, 8'b0); end
      cyc(); cyc(); cyc();
      vectors++;
      if (o8 !== 8'b00_00_0000) begin miscompares++; $display("FAIL mdrst_held: got %b required %b", o8, 8'b0); end
      clr();
      rst_n = 1'b1;
      cyc(); cyc();
      vectors++;
      if (o8 !== 8'b00_00_0000) begin miscompares++; $display("FAIL mdrst_idle: got %b required %b", o8, 8'b0); end
   endtask

   task automatic test_fwd_ex();
      clr();
      b4.ex_rd = 5'd5; b4.ex_regwrite = 1'b1; b4.id_rs = 5'd5; b4.id_use_rs = 1'b1;
      cyc();
      vectors++;
      if (o4 !== 8'b01_00_0000) begin miscompares++; $display("FAIL fwd_ex_a: got %b required %b", o4, 8'b01_00_0000); end
      b4.ex_rd = 5'd0; b4.id_rs = 5'd0;
      cyc();
      vectors++;
      if (o4 !== 8'b00_00_0000) begin miscompares++; $display("FAIL fwd_r0: got %b required %b", o4, 8'b0); end
      b4.ex_rd = 5'd5; b4.id_rs = 5'd5; b4.id_use_rs = 1'b0;
      cyc();
      vectors++;
      if (o4 !== 8'b00_00_0000) begin miscompares++; $display("FAIL fwd_nouse: got %b required %b", o4, 8'b0); end
      b4.id_use_rs = 1'b1; b4.id_rt = 5'd5; b4.id_use_rt = 1'b1;
      cyc();
      vectors++;
      if (o4 !== 8'b01_01_0000) begin miscompares++; $display("FAIL fwd_both: got %b required %b", o4, 8'b01_01_0000); end
   endtask

   task automatic test_fwd_mem();
      clr();
      b4.ex_rd = 5'd7; b4.ex_regwrite = 1'b1; b4.mem_rd = 5'd7; b4.mem_regwrite = 1'b1;
      b4.id_rt = 5'd7; b4.id_use_rt = 1'b1;
      cyc();
      vectors++;
      if (o4 !== 8'b00_01_0000) begin miscompares++; $display("FAIL fwd_prio: got %b required %b", o4, 8'b00_01_0000); end
      b4.ex_regwrite = 1'b0;
      cyc();
      vectors++;
      if (o4 !== 8'b00_10_0000) begin miscompares++; $display("FAIL fwd_mem: got %b required %b", o4, 8'b00_10_0000); end
      b4.mem_rd = 5'd0; b4.id_rt = 5'd0;
      cyc();
      vectors++;
      if (o4 !== 8'b00_00_0000) begin miscompares++; $display("FAIL fwd_mem_r0: got %b required %b", o4, 8'b0); end
      b4.id_rs = 5'd9; b4.id_use_rs = 1'b1; b4.mem_rd = 5'd9;
      b4.id_rt = 5'd4; b4.ex_rd = 5'd4; b4.ex_regwrite = 1'b1;
      cyc();
      vectors++;
      if (o4 !== 8'b10_01_0000) begin miscompares++; $display("FAIL fwd_mixed: got %b required %b", o4, 8'b10_01_0000); end
   endtask

   task automatic test_load_use();
      clr();
      cyc();
      b4.ex_memread = 1'b1; b4.ex_regwrite = 1'b1; b4.ex_rd = 5'd3;
      b4.id_rt = 5'd3; b4.id_use_rt = 1'b1;
      #1;
      vectors++;
      if (o4 !== 8'b00_00_1100) begin miscompares++; $display("FAIL lu_stall: got %b required %b", o4, 8'b00_00_1100); end
      cyc();
      vectors++;
      if (o4 !== 8'b00_00_1100) begin miscompares++; $display("FAIL lu_bubble_sel: got %b required %b", o4, 8'b00_00_1100); end
      b4.id_use_rt = 1'b0;
      #1;
      vectors++;
      if (o4 !== 8'b00_00_0000) begin miscompares++; $display("FAIL lu_nouse: got %b required %b", o4, 8'b0); end
      b4.ex_rd = 5'd0; b4.id_rt = 5'd0; b4.id_use_rt = 1'b1;
      #1;
      vectors++;
      if (o4 !== 8'b00_00_0000) begin miscompares++; $display("FAIL lu_r0: got %b required %b", o4, 8'b0); end
      b4.ex_rd = 5'd3; b4.id_use_rt = 1'b0; b4.id_rs = 5'd3; b4.id_use_rs = 1'b1;
      #1;
      vectors++;
      if (o4 !== 8'b00_00_1100) begin miscompares++; $display("FAIL lu_rs: got %b required %b", o4, 8'b00_00_1100); end
   endtask

   task automatic test_md_lat();
      logic [7:0] exp4;
      logic       exp8;
      wait_idle();
      cyc();
      b4.id_md_op = 1'b1;                     // cycle 0
      #1;
      vectors++;
      if (o4 !== 8'b00_00_0000) begin miscompares++; $display("FAIL md_c0: got %b required %b", o4, 8'b0); end
      cyc();
      b4.id_md_op = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         b4.id_md_read = (c >= 2 && c <= 5);
         #1;
         exp4 = {4'b0000, (c >= 2 && c <= 4), (c >= 2 && c <= 4), 1'b0, (c <= 4)};
         exp8 = (c <= 8);
         vectors++;
         if (o4 !== exp4) begin miscompares++; $display("FAIL md4_c%0d: got %b required %b", c, o4, exp4); end
         vectors++;
         if (b8.md_busy !== exp8) begin miscompares++; $display("FAIL md8_c%0d: got %b required %b", c, b8.md_busy, exp8); end
         cyc();
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp4;
      wait_idle();
      cyc();
      b4.id_md_op = 1'b1;                     // held in ID: accepted again on first idle cycle
      for (int c = 0; c <= 5; c++) begin
         #1;
         exp4 = (c >= 1 && c <= 4) ? 8'b00_00_1101 : 8'b00_00_0000;
         vectors++;
         if (o4 !== exp4) begin miscompares++; $display("FAIL b2b_c%0d: got %b required %b", c, o4, exp4); end
         cyc();
      end
      b4.id_md_op = 1'b0;
      #1;
      vectors++;
      if (o4 !== 8'b00_00_0001) begin miscompares++; $display("FAIL b2b_restart: got %b required %b", o4, 8'b00_00_0001); end
   endtask

   task automatic test_lu_blocks_start();
      wait_idle();
      cyc();
      b4.id_md_op = 1'b1;
      b4.ex_memread = 1'b1; b4.ex_rd = 5'd3; b4.id_rs = 5'd3; b4.id_use_rs = 1'b1;
      #1;
      vectors++;
      if (o4 !== 8'b00_00_1100) begin miscompares++; $display("FAIL lustart_stall: got %b required %b", o4, 8'b00_00_1100); end
      cyc();
      b4.ex_memread = 1'b0;
      #1;
      vectors++;
      if (o4 !== 8'b00_00_0000) begin miscompares++; $display("FAIL lustart_blocked: got %b required %b", o4, 8'b0); end
      cyc();
      b4.id_md_op = 1'b0;
      #1;
      vectors++;
      if (o4 !== 8'b00_00_0001) begin miscompares++; $display("FAIL lustart_go: got %b required %b", o4, 8'b00_00_0001); end
   endtask

   task automatic test_branch();
      wait_idle();
      cyc();
      b4.ex_branch_taken = 1'b1; b4.id_md_op = 1'b1;
      b4.ex_memread = 1'b1; b4.ex_regwrite = 1'b1; b4.ex_rd = 5'd3;
      b4.id_rs = 5'd3; b4.id_use_rs = 1'b1;
      #1;
      vectors++;
      if (o4 !== 8'b00_00_0110) begin miscompares++; $display("FAIL br_flush: got %b required %b", o4, 8'b00_00_0110); end
      cyc();
      clr();
      #1;
      vectors++;
      if (o4 !== 8'b00_00_0000) begin miscompares++; $display("FAIL br_nostart: got %b required %b", o4, 8'b0); end
      b4.id_md_op = 1'b1;
      cyc();
      b4.id_md_op = 1'b0; b4.id_md_read = 1'b1; b4.ex_branch_taken = 1'b1;
      #1;
      vectors++;
      if (o4 !== 8'b00_00_0111) begin miscompares++; $display("FAIL br_busy: got %b required %b", o4, 8'b00_00_0111); end
   endtask

   initial begin
      test_reset();
      test_md_reset();
      test_fwd_ex();
      test_fwd_mem();
      test_load_use();
      test_md_lat();
      test_back_to_back();
      test_lu_blocks_start();
      test_branch();
      wait_idle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
